// File: rtl/sdram_pkg.sv
// Shared FSM encoding and round-robin selection helper for the SDRAM arbiter.
// Supports up to MaxPorts requesters.
package sdram_pkg;

  localparam int unsigned MaxPorts = 4;

  typedef logic [1:0] state_t;

  localparam state_t StIdle     = 2'd0;
  localparam state_t StIssue    = 2'd1;
  localparam state_t StWaitDone = 2'd2;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } rr_pick_t;

  // Search starts at the port after the last one served, wrapping at num.
  function automatic rr_pick_t rr_select(input logic [MaxPorts-1:0] req,
                                         input logic [1:0]          last,
                                         input int unsigned         num);
    rr_pick_t   pick;
    logic [1:0] cand;
    pick = '0;
    for (int unsigned off = 1; off <= MaxPorts; off++) begin
      cand = 2'((32'(last) + off) % num);
      if (off <= num && !pick.found && req[cand]) begin
        pick.found = 1'b1;
        pick.idx   = cand;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: request vector plus last grant in,
// one-hot grant and index out.
module rr_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned NumPorts = 2,
  parameter int unsigned IdxW     = $clog2(NumPorts)
) (
  input  logic [NumPorts-1:0] req_i,
  input  logic [IdxW-1:0]     last_i,
  output logic [NumPorts-1:0] gnt_o,
  output logic [IdxW-1:0]     idx_o,
  output logic                any_o
);

  logic [MaxPorts-1:0] req_pad;
  logic [1:0]          last_pad;
  rr_pick_t            pick;
  logic                unused_pick;

  always_comb begin
    req_pad                 = '0;
    req_pad[NumPorts-1:0]   = req_i;
    last_pad                = '0;
    last_pad[IdxW-1:0]      = last_i;
    pick                    = rr_select(req_pad, last_pad, NumPorts);
    any_o                   = pick.found;
    idx_o                   = pick.idx[IdxW-1:0];
    gnt_o                   = '0;
    if (pick.found) begin
      gnt_o[idx_o] = 1'b1;
    end
  end

  // Index bits above IdxW are always zero for small port counts.
  assign unused_pick = ^pick;

endmodule

// File: rtl/sdram_arbiter.sv
// Multi-port request arbiter in front of a single SDRAM controller.
// One transaction outstanding at a time; round-robin fairness across ports.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned IdxW      = $clog2(NUM_PORTS),
  localparam int unsigned StrbW     = DATA_WIDTH / 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_PORTS-1:0]            req_valid_i,
  output logic [NUM_PORTS-1:0]            req_ready_o,
  input  logic [NUM_PORTS-1:0]            req_we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata_i,
  input  logic [NUM_PORTS*StrbW-1:0]      req_wstrb_i,
  output logic [NUM_PORTS-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]           rsp_rdata_o,
  output logic                            cmd_valid_o,
  input  logic                            cmd_ready_i,
  output logic                            cmd_we_o,
  output logic [ADDR_WIDTH-1:0]           cmd_addr_o,
  output logic [DATA_WIDTH-1:0]           cmd_wdata_o,
  output logic [StrbW-1:0]                cmd_wstrb_o,
  input  logic                            cmd_done_i,
  input  logic [DATA_WIDTH-1:0]           cmd_rdata_i,
  output logic [IdxW-1:0]                 grant_id_o,
  output logic                            err_spurious_o
);

  state_t                 state_q, state_d;
  logic [IdxW-1:0]        grant_q, grant_d;
  logic [IdxW-1:0]        last_q, last_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [StrbW-1:0]       wstrb_q, wstrb_d;
  logic [NUM_PORTS-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic [NUM_PORTS-1:0]   arb_gnt;
  logic [IdxW-1:0]        arb_idx;
  logic                   arb_any;

  rr_arbiter #(
    .NumPorts (NUM_PORTS),
    .IdxW     (IdxW)
  ) u_rr (
    .req_i  (req_valid_i),
    .last_i (last_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .any_o  (arb_any)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    rsp_valid_d = '0;
    req_ready_o = '0;
    // A completion outside WAIT_DONE has no owner; flag it and drop it.
    err_d       = err_q | (cmd_done_i && (state_q != StWaitDone));

    case (state_q)
      StIdle: begin
        req_ready_o = arb_gnt;
        if (arb_any) begin
          grant_d = arb_idx;
          we_d    = req_we_i[arb_idx];
          addr_d  = req_addr_i[32'(arb_idx) * ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = req_wdata_i[32'(arb_idx) * DATA_WIDTH +: DATA_WIDTH];
          wstrb_d = req_wstrb_i[32'(arb_idx) * StrbW +: StrbW];
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (cmd_ready_i) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (cmd_done_i) begin
          rsp_valid_d[grant_q] = 1'b1;
          rdata_d              = cmd_rdata_i;
          last_d               = grant_q;
          state_d              = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      last_q      <= IdxW'(NUM_PORTS - 1);
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign cmd_valid_o    = (state_q == StIssue);
  assign cmd_we_o       = we_q;
  assign cmd_addr_o     = addr_q;
  assign cmd_wdata_o    = wdata_q;
  assign cmd_wstrb_o    = wstrb_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_rdata_o    = rdata_q;
  assign grant_id_o     = grant_q;
  assign err_spurious_o = err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: directed transactions push expected responses,
// a monitor pops them as rsp_valid pulses appear; a small controller model answers commands.
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_we, req_ready, rsp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic [31:0] rsp_rdata, cmd_addr, cmd_wdata, cmd_rdata;
  logic        cmd_valid, cmd_ready, cmd_we, cmd_done, ctl_done, spur_done, err;
  logic [3:0]  cmd_wstrb;
  logic [0:0]  grant_id;

  typedef struct {
    logic [1:0]  port_oh;
    logic        we;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic [0:0]  gid;
    logic        we;
    logic [31:0] addr;
  } cmd_t;

  exp_t sb[$];
  cmd_t log_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rst_count = 0;
  int   done_delay = 3;

  assign cmd_done = ctl_done | spur_done;

  sdram_arbiter dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .req_wstrb_i    (req_wstrb),
    .rsp_valid_o    (rsp_valid),
    .rsp_rdata_o    (rsp_rdata),
    .cmd_valid_o    (cmd_valid),
    .cmd_ready_i    (cmd_ready),
    .cmd_we_o       (cmd_we),
    .cmd_addr_o     (cmd_addr),
    .cmd_wdata_o    (cmd_wdata),
    .cmd_wstrb_o    (cmd_wstrb),
    .cmd_done_i     (cmd_done),
    .cmd_rdata_i    (cmd_rdata),
    .grant_id_o     (grant_id),
    .err_spurious_o (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ctl_rdata(input logic [31:0] addr);
    return (addr == 32'h100) ? 32'hDEAD_BEEF : ~addr;
  endfunction

  // Controller model: accept on handshake, pulse done done_delay cycles later.
  initial begin
    int gen;
    ctl_done  = 1'b0;
    cmd_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && cmd_valid && cmd_ready) begin
        gen = rst_count;
        log_q.push_back('{gid: grant_id, we: cmd_we, addr: cmd_addr});
        cmd_rdata = ctl_rdata(cmd_addr);
        @(posedge clk);
        #1;
        for (int i = 1; i < done_delay; i++) begin
          if (gen != rst_count) break;
          @(posedge clk);
        end
        #1;
        if (gen == rst_count) begin
          ctl_done = 1'b1;
          @(posedge clk);
          #1;
          ctl_done = 1'b0;
        end
      end
    end
  end

  // Response monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid != 2'b00) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 96'(rsp_valid), 96'(0));
        end else begin
          e = sb.pop_front();
          check("rsp_port", 96'(rsp_valid), 96'(e.port_oh));
          if (!e.we) check("rsp_rdata", 96'(rsp_rdata), 96'(e.rdata));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    rst_count++;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    log_q.delete();
    rst = 1'b0;
  endtask

  task automatic set_port(input int p, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb);
    req_we[p]             = we;
    req_addr[p*32 +: 32]  = addr;
    req_wdata[p*32 +: 32] = wdata;
    req_wstrb[p*4 +: 4]   = strb;
  endtask

  task automatic issue(input int p, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb);
    bit found = 0;
    set_port(p, we, addr, wdata, strb);
    req_valid[p] = 1'b1;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (req_ready[p]) found = 1;
    end
    if (!found) check("grant_timeout", 96'(0), 96'(1));
    @(posedge clk);
    #1;
    req_valid[p] = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 96'(sb.size()), 96'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] order[4];
    logic [1:0] exp_order[4];
    int n;
    exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    req_wstrb = '0; cmd_ready = 1'b0; spur_done = 1'b0;
    do_reset();

    // Reset values.
    @(negedge clk);
    check("rst_req_ready", 96'(req_ready), 96'(0));
    check("rst_cmd_valid", 96'(cmd_valid), 96'(0));
    check("rst_rsp_valid", 96'(rsp_valid), 96'(0));
    check("rst_rsp_rdata", 96'(rsp_rdata), 96'(0));
    check("rst_grant_id", 96'(grant_id), 96'(0));
    check("rst_err", 96'(err), 96'(0));
    check("rst_payload", {cmd_we, cmd_addr, cmd_wdata, cmd_wstrb}, 96'(0));

    // Port 0 read, done 3 cycles after handshake.
    do_reset();
    cmd_ready  = 1'b1;
    done_delay = 3;
    sb.push_back('{port_oh: 2'b01, we: 1'b0, rdata: 32'hDEAD_BEEF});
    issue(0, 1'b0, 32'h100, 32'h0, 4'h0);
    wait_drain();
    check("rd_grant_id", 96'(grant_id), 96'(0));
    check("rd_cmd_count", 96'(log_q.size()), 96'(1));
    check("rd_cmd_addr", 96'(log_q[0].addr), 96'(32'h100));

    // Both ports continuously valid: grants alternate starting at port 0.
    do_reset();
    done_delay = 2;
    set_port(0, 1'b1, 32'h1000, 32'hA0A0_A0A0, 4'hF);
    set_port(1, 1'b1, 32'h1004, 32'hB1B1_B1B1, 4'hF);
    for (int k = 0; k < 4; k++) sb.push_back('{port_oh: exp_order[k], we: 1'b1, rdata: '0});
    req_valid = 2'b11;
    n = 0;
    for (int i = 0; i < 200 && n < 4; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        order[n] = req_ready;
        n++;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    check("rr_grant_count", 96'(n), 96'(4));
    for (int k = 0; k < 4; k++) check($sformatf("rr_order_%0d", k), 96'(order[k]), 96'(exp_order[k]));
    wait_drain();

    // Port 1 write held off by cmd_ready low: payload must stay put.
    do_reset();
    cmd_ready = 1'b0;
    sb.push_back('{port_oh: 2'b10, we: 1'b1, rdata: '0});
    issue(1, 1'b1, 32'h2000, 32'h1234_5678, 4'h3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("hold_%0d", c), {cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb},
            {1'b1, 1'b1, 32'h2000, 32'h1234_5678, 4'h3});
    end
    @(posedge clk);
    #1;
    cmd_ready = 1'b1;
    wait_drain();
    check("hold_handshakes", 96'(log_q.size()), 96'(1));
    check("hold_grant_id", 96'(grant_id), 96'(1));

    // Spurious completion while idle.
    do_reset();
    @(posedge clk);
    #1;
    spur_done = 1'b1;
    @(posedge clk);
    #1;
    spur_done = 1'b0;
    @(negedge clk);
    check("spur_err_set", 96'(err), 96'(1));
    repeat (4) @(negedge clk);
    check("spur_err_sticky", 96'(err), 96'(1));
    check("spur_idle", 96'(cmd_valid), 96'(0));
    do_reset();
    @(negedge clk);
    check("spur_err_clr", 96'(err), 96'(0));

    // Reset in WAIT_DONE abandons the transaction.
    do_reset();
    cmd_ready  = 1'b1;
    done_delay = 6;
    issue(1, 1'b0, 32'h300, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    check("wd_state", {cmd_valid, grant_id}, 96'({1'b0, 1'b1}));
    rst = 1'b1;
    rst_count++;
    req_valid = '0;
    #1;
    check("wd_rst_outputs", {req_ready, cmd_valid, rsp_valid, rsp_rdata, grant_id}, 96'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    log_q.delete();
    set_port(0, 1'b0, 32'h40, 32'h0, 4'h0);
    set_port(1, 1'b0, 32'h80, 32'h0, 4'h0);
    done_delay = 3;
    sb.push_back('{port_oh: 2'b01, we: 1'b0, rdata: 32'hFFFF_FFBF});
    req_valid = 2'b11;
    n = 0;
    for (int i = 0; i < 20 && n == 0; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        order[0] = req_ready;
        n = 1;
      end
    end
    check("wd_first_grant", 96'(order[0]), 96'(2'b01));
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    wait_drain();
    repeat (3) @(negedge clk);
    check("final_sb_empty", 96'(sb.size()), 96'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
